// File: rtl/data_mem_arbiter_if.sv
// Bundle between the data-memory arbiter, its three requesters and the data memory.
// The arbiter uses the slave modport; requesters and memory sit on the master side.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic [2:0]          req;
  logic [2:0]          we;
  logic [3*ADDR_W-1:0] addr;
  logic [3*DATA_W-1:0] wdata;
  logic [2:0]          gnt;
  logic [2:0]          done;
  logic [DATA_W-1:0]   rdata;
  logic [2:0]          collision;
  logic                busy;
  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output gnt, done, rdata, collision, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  gnt, done, rdata, collision, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between control unit,
// stack and crypto core; each request is latched, served, and answered with done.
module data_mem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input logic               clk,
  input logic               rst,
  data_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [1:0]        winner, winner_nxt;
  logic [1:0]        last, last_nxt;
  logic [1:0]        lat_cnt, lat_cnt_nxt;
  logic              capture;
  logic [DATA_W-1:0] rdata_q;
  logic [2:0]        pend;
  logic [2:0]        coll_q;
  logic [2:0]        slot_we;
  logic [ADDR_W-1:0] slot_addr  [3];
  logic [DATA_W-1:0] slot_wdata [3];
  logic [2:0]        resp_hit;
  logic              issue;

  // Search starts just after the last served requester, so the lowest offset wins.
  function automatic logic [1:0] rr_pick(input logic [2:0] p, input logic [1:0] l);
    logic [1:0] pick;
    pick = l;
    for (int k = 3; k >= 1; k--) begin
      if (p[(int'(l) + k) % 3]) pick = 2'((int'(l) + k) % 3);
    end
    return pick;
  endfunction

  always_comb begin
    resp_hit = '0;
    for (int i = 0; i < 3; i++) begin
      resp_hit[i] = (state == RESP) && (winner == 2'(i));
    end
  end

  always_comb begin
    state_nxt   = state;
    winner_nxt  = winner;
    last_nxt    = last;
    lat_cnt_nxt = lat_cnt;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        if (|pend) begin
          winner_nxt = rr_pick(pend, last);
          state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        if (slot_we[winner]) begin
          state_nxt = RESP;
        end else begin
          lat_cnt_nxt = 2'(MEM_LAT);
          state_nxt   = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt == 2'd1) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else begin
          lat_cnt_nxt = lat_cnt - 2'd1;
        end
      end
      RESP: begin
        last_nxt  = winner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      winner  <= 2'd0;
      last    <= 2'd2;
      lat_cnt <= 2'd0;
      rdata_q <= '0;
    end else begin
      state   <= state_nxt;
      winner  <= winner_nxt;
      last    <= last_nxt;
      lat_cnt <= lat_cnt_nxt;
      if (capture) rdata_q <= bus.mem_rdata;
    end
  end

  // A new pulse in the requester's own RESP cycle is accepted: set beats clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend    <= '0;
      coll_q  <= '0;
      slot_we <= '0;
      for (int i = 0; i < 3; i++) begin
        slot_addr[i]  <= '0;
        slot_wdata[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (bus.req[i] && (!pend[i] || resp_hit[i])) begin
          pend[i]       <= 1'b1;
          slot_we[i]    <= bus.we[i];
          slot_addr[i]  <= bus.addr[i*ADDR_W +: ADDR_W];
          slot_wdata[i] <= bus.wdata[i*DATA_W +: DATA_W];
        end else begin
          if (bus.req[i]) coll_q[i] <= 1'b1;
          if (resp_hit[i]) pend[i] <= 1'b0;
        end
      end
    end
  end

  assign issue         = (state == ISSUE);
  assign bus.mem_en    = issue;
  assign bus.mem_we    = issue & slot_we[winner];
  assign bus.mem_addr  = issue ? slot_addr[winner] : '0;
  assign bus.mem_wdata = issue ? slot_wdata[winner] : '0;
  assign bus.gnt       = issue ? 3'(3'b001 << winner) : 3'b000;
  assign bus.done      = (state == RESP) ? 3'(3'b001 << winner) : 3'b000;
  assign bus.rdata     = rdata_q;
  assign bus.collision = coll_q;
  assign bus.busy      = (state != IDLE) || (|pend);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed cycle table and reset-abort sequence,
// then randomized traffic checked against a cycle-timeline transaction model.
module tb_data_mem_arbiter;

  localparam int AW   = 8;
  localparam int DW   = 16;
  localparam int RLAT = 1;

  logic clk = 1'b0;
  logic rst1;
  logic rst3;

  always #5 clk = ~clk;

  data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));
  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) dut3 (.clk(clk), .rst(rst3), .bus(bus3));

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 16'hBEEF : {8'hC0, a};
  endfunction

  // Memories return DEAD on non-read cycles so a mistimed capture is visible.
  logic [15:0] mem1 [256];
  logic [15:0] mem3 [256];
  logic [15:0] rd1;
  logic [15:0] rd3 [3];
  bit          loaded = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int a = 0; a < 256; a++) begin
        mem1[a] <= init_val(8'(a));
        mem3[a] <= init_val(8'(a));
      end
      loaded <= 1'b1;
    end else begin
      if (bus1.mem_en && bus1.mem_we) mem1[bus1.mem_addr] <= bus1.mem_wdata;
      rd1 <= (bus1.mem_en && !bus1.mem_we) ? mem1[bus1.mem_addr] : 16'hDEAD;
      if (bus3.mem_en && bus3.mem_we) mem3[bus3.mem_addr] <= bus3.mem_wdata;
      rd3[0] <= (bus3.mem_en && !bus3.mem_we) ? mem3[bus3.mem_addr] : 16'hDEAD;
      rd3[1] <= rd3[0];
      rd3[2] <= rd3[1];
    end
  end

  assign bus1.mem_rdata = rd1;
  assign bus3.mem_rdata = rd3[2];

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] r, input logic [2:0] w,
                               input logic [23:0] a, input logic [47:0] d);
    bus1.req   = r;
    bus1.we    = w;
    bus1.addr  = a;
    bus1.wdata = d;
  endtask

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  we;
    logic [7:0]  addr;
    logic [15:0] wd;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic        mwe;
    logic [7:0]  maddr;
    logic [15:0] mwd;
    logic [15:0] rdata;
    logic [2:0]  coll;
    logic        busy;
  } vec_t;

  vec_t rows[$];

  function automatic vec_t v(input logic [2:0] req, input logic [2:0] we, input logic [7:0] addr,
                             input logic [15:0] wd, input logic [2:0] gnt, input logic [2:0] done,
                             input logic mwe, input logic [7:0] maddr, input logic [15:0] mwd,
                             input logic [15:0] rdata, input logic [2:0] coll, input logic busy);
    vec_t t;
    t.req = req; t.we = we; t.addr = addr; t.wd = wd; t.gnt = gnt; t.done = done;
    t.mwe = mwe; t.maddr = maddr; t.mwd = mwd; t.rdata = rdata; t.coll = coll; t.busy = busy;
    return t;
  endfunction

  // Transaction-timeline reference model: each grant fixes its ISSUE and done cycles.
  int          m_cyc, m_cur, m_tiss, m_tdone, m_last;
  logic [2:0]  m_pend, m_coll, m_swe;
  logic [7:0]  m_sadr [3];
  logic [15:0] m_swd  [3];
  logic        m_cwe;
  logic [7:0]  m_cadr;
  logic [15:0] m_cwd;
  logic [15:0] m_rd;
  logic [15:0] ref_mem [256];

  task automatic model_reset();
    m_cyc = 0; m_cur = -1; m_tiss = -1; m_tdone = -1; m_last = 2;
    m_pend = '0; m_coll = '0; m_swe = '0; m_rd = '0;
  endtask

  task automatic model_check();
    logic [2:0] eg, ed;
    eg = (m_cur >= 0 && m_cyc == m_tiss)  ? 3'(1 << m_cur) : 3'b000;
    ed = (m_cur >= 0 && m_cyc == m_tdone) ? 3'(1 << m_cur) : 3'b000;
    if (ed != 3'b000 && !m_cwe) m_rd = ref_mem[m_cadr];
    checkOutput("rand gnt",       32'(bus1.gnt),       32'(eg));
    checkOutput("rand done",      32'(bus1.done),      32'(ed));
    checkOutput("rand rdata",     32'(bus1.rdata),     32'(m_rd));
    checkOutput("rand collision", 32'(bus1.collision), 32'(m_coll));
    checkOutput("rand busy",      32'(bus1.busy),      32'((m_cur >= 0) || (m_pend != 3'b000)));
    checkOutput("rand mem_en",    32'(bus1.mem_en),    32'(eg != 3'b000));
    if (eg != 3'b000) begin
      checkOutput("rand mem_addr", 32'(bus1.mem_addr), 32'(m_cadr));
      checkOutput("rand mem_we",   32'(bus1.mem_we),   32'(m_cwe));
      if (m_cwe) checkOutput("rand mem_wdata", 32'(bus1.mem_wdata), 32'(m_cwd));
    end
  endtask

  task automatic model_step(input logic [2:0] r, input logic [2:0] w,
                            input logic [7:0] a [3], input logic [15:0] d [3]);
    if (m_cur >= 0 && m_cyc == m_tiss && m_cwe) ref_mem[m_cadr] = m_cwd;
    if (m_cur >= 0 && m_cyc == m_tdone) begin
      m_pend[m_cur] = 1'b0;
      m_last = m_cur;
      m_cur = -1;
    end else if (m_cur < 0 && m_pend != 3'b000) begin
      for (int k = 1; k <= 3; k++) begin
        int j;
        j = (m_last + k) % 3;
        if (m_cur < 0 && m_pend[j]) begin
          m_cur = j; m_cwe = m_swe[j]; m_cadr = m_sadr[j]; m_cwd = m_swd[j];
          m_tiss = m_cyc + 1;
          m_tdone = m_cyc + 2 + (m_swe[j] ? 0 : RLAT);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (r[i]) begin
        if (m_pend[i]) m_coll[i] = 1'b1;
        else begin
          m_pend[i] = 1'b1; m_swe[i] = w[i]; m_sadr[i] = a[i]; m_swd[i] = d[i];
        end
      end
    end
    m_cyc++;
  endtask

  initial begin
    logic [2:0]  r, w;
    logic [7:0]  ra [3];
    logic [15:0] rdv [3];

    // Directed cycle table: inputs for the cycle, then outputs expected in that cycle.
    rows.push_back(v(1,0,'h10,0,      0,0,0,0,0,      0,0,0));
    rows.push_back(v(0,0,0,0,         0,0,0,0,0,      0,0,1));
    rows.push_back(v(0,0,0,0,         1,0,0,'h10,0,   0,0,1));
    rows.push_back(v(0,0,0,0,         0,0,0,0,0,      0,0,1));
    rows.push_back(v(0,0,0,0,         0,1,0,0,0,      'hBEEF,0,1));
    rows.push_back(v(2,2,'hFF,'h1234, 0,0,0,0,0,      'hBEEF,0,0));
    rows.push_back(v(0,0,0,0,         0,0,0,0,0,      'hBEEF,0,1));
    rows.push_back(v(0,0,0,0,         2,0,1,'hFF,'h1234, 'hBEEF,0,1));
    rows.push_back(v(0,0,0,0,         0,2,0,0,0,      'hBEEF,0,1));
    rows.push_back(v(1,0,'hFF,0,      0,0,0,0,0,      'hBEEF,0,0));
    rows.push_back(v(0,0,0,0,         0,0,0,0,0,      'hBEEF,0,1));
    rows.push_back(v(0,0,0,0,         1,0,0,'hFF,0,   'hBEEF,0,1));
    rows.push_back(v(0,0,0,0,         0,0,0,0,0,      'hBEEF,0,1));
    rows.push_back(v(0,0,0,0,         0,1,0,0,0,      'h1234,0,1));
    rows.push_back(v(4,0,'h30,0,      0,0,0,0,0,      'h1234,0,0));
    rows.push_back(v(4,0,'h31,0,      0,0,0,0,0,      'h1234,0,1));
    rows.push_back(v(0,0,0,0,         4,0,0,'h30,0,   'h1234,4,1));
    rows.push_back(v(0,0,0,0,         0,0,0,0,0,      'h1234,4,1));
    rows.push_back(v(0,0,0,0,         0,4,0,0,0,      'hC030,4,1));
    for (int rep = 0; rep < 2; rep++) begin
      logic [7:0]  ad;
      logic [15:0] prev, cur;
      ad   = (rep == 0) ? 8'h20 : 8'h21;
      prev = (rep == 0) ? 16'hC030 : 16'hC020;
      cur  = init_val(ad);
      rows.push_back(v(7,0,ad,0, 0,0,0,0,0, prev,4,0));
      rows.push_back(v(0,0,0,0,  0,0,0,0,0, prev,4,1));
      for (int g = 0; g < 3; g++) begin
        rows.push_back(v(0,0,0,0, 3'(1 << g),0,0,ad,0, (g == 0) ? prev : cur,4,1));
        rows.push_back(v(0,0,0,0, 0,0,0,0,0,           (g == 0) ? prev : cur,4,1));
        rows.push_back(v(0,0,0,0, 0,3'(1 << g),0,0,0,  cur,4,1));
        if (g < 2) rows.push_back(v(0,0,0,0, 0,0,0,0,0, cur,4,1));
      end
    end
    rows.push_back(v(1,0,'h40,0,      0,0,0,0,0,      'hC021,4,0));
    rows.push_back(v(0,0,0,0,         0,0,0,0,0,      'hC021,4,1));
    rows.push_back(v(0,0,0,0,         1,0,0,'h40,0,   'hC021,4,1));
    rows.push_back(v(0,0,0,0,         0,0,0,0,0,      'hC021,4,1));
    rows.push_back(v(1,0,'h41,0,      0,1,0,0,0,      'hC040,4,1));
    rows.push_back(v(0,0,0,0,         0,0,0,0,0,      'hC040,4,1));
    rows.push_back(v(0,0,0,0,         1,0,0,'h41,0,   'hC040,4,1));
    rows.push_back(v(0,0,0,0,         0,0,0,0,0,      'hC040,4,1));
    rows.push_back(v(0,0,0,0,         0,1,0,0,0,      'hC041,4,1));
    rows.push_back(v(0,0,0,0,         0,0,0,0,0,      'hC041,4,0));

    for (int a = 0; a < 256; a++) ref_mem[a] = init_val(8'(a));
    rst1 = 1'b0;
    rst3 = 1'b0;
    applyStimulus(3'b000, 3'b000, 24'h0, 48'h0);
    bus3.req = 3'b000; bus3.we = 3'b000; bus3.addr = '0; bus3.wdata = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset ctl", 32'({bus1.gnt, bus1.done, bus1.collision, bus1.busy, bus1.mem_en, bus1.mem_we}), 32'h0);
    checkOutput("reset rdata", 32'(bus1.rdata), 32'h0);
    checkOutput("reset mem bus", 32'({bus1.mem_addr, bus1.mem_wdata}), 32'h0);
    rst1 = 1'b1;
    rst3 = 1'b1;

    for (int k = 0; k < rows.size(); k++) begin
      checkOutput($sformatf("row%0d gnt", k),       32'(bus1.gnt),       32'(rows[k].gnt));
      checkOutput($sformatf("row%0d done", k),      32'(bus1.done),      32'(rows[k].done));
      checkOutput($sformatf("row%0d mem_en", k),    32'(bus1.mem_en),    32'(rows[k].gnt != 3'b000));
      checkOutput($sformatf("row%0d mem_we", k),    32'(bus1.mem_we),    32'(rows[k].mwe));
      checkOutput($sformatf("row%0d mem_addr", k),  32'(bus1.mem_addr),  32'(rows[k].maddr));
      checkOutput($sformatf("row%0d mem_wdata", k), 32'(bus1.mem_wdata), 32'(rows[k].mwd));
      checkOutput($sformatf("row%0d rdata", k),     32'(bus1.rdata),     32'(rows[k].rdata));
      checkOutput($sformatf("row%0d collision", k), 32'(bus1.collision), 32'(rows[k].coll));
      checkOutput($sformatf("row%0d busy", k),      32'(bus1.busy),      32'(rows[k].busy));
      applyStimulus(rows[k].req, rows[k].we, {3{rows[k].addr}}, {3{rows[k].wd}});
      @(negedge clk);
    end
    applyStimulus(3'b000, 3'b000, 24'h0, 48'h0);

    // Three-cycle latency read, then a reset dropped in the middle of WAIT.
    bus3.req = 3'b001; bus3.addr = {3{8'h10}};
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      bus3.req = 3'b000;
      checkOutput($sformatf("lat3 c%0d gnt", cyc),   32'(bus3.gnt),   (cyc == 2) ? 32'h1 : 32'h0);
      checkOutput($sformatf("lat3 c%0d done", cyc),  32'(bus3.done),  (cyc == 6) ? 32'h1 : 32'h0);
      checkOutput($sformatf("lat3 c%0d busy", cyc),  32'(bus3.busy),  (cyc <= 6) ? 32'h1 : 32'h0);
      checkOutput($sformatf("lat3 c%0d rdata", cyc), 32'(bus3.rdata), (cyc >= 6) ? 32'hBEEF : 32'h0);
    end
    bus3.req = 3'b001; bus3.addr = {3{8'h20}};
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      bus3.req = 3'b000;
      checkOutput($sformatf("abort c%0d gnt", cyc), 32'(bus3.gnt), (cyc == 2) ? 32'h1 : 32'h0);
    end
    checkOutput("abort busy before reset", 32'(bus3.busy), 32'h1);
    rst3 = 1'b0;
    #1;
    checkOutput("abort reset ctl", 32'({bus3.gnt, bus3.done, bus3.collision, bus3.busy, bus3.mem_en, bus3.mem_we}), 32'h0);
    checkOutput("abort reset rdata", 32'(bus3.rdata), 32'h0);
    checkOutput("abort reset mem bus", 32'({bus3.mem_addr, bus3.mem_wdata}), 32'h0);
    repeat (2) @(negedge clk);
    rst3 = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      checkOutput($sformatf("post-abort c%0d", cyc),
                  32'({bus3.done, bus3.busy, bus3.mem_en, bus3.rdata}), 32'h0);
    end

    // Randomized epochs, each opened by an asynchronous reset at an arbitrary point.
    for (int ep = 0; ep < 8; ep++) begin
      @(negedge clk);
      applyStimulus(3'b000, 3'b000, 24'h0, 48'h0);
      rst1 = 1'b0;
      #1;
      checkOutput("epoch reset ctl", 32'({bus1.gnt, bus1.done, bus1.collision, bus1.busy, bus1.mem_en, bus1.mem_we}), 32'h0);
      checkOutput("epoch reset rdata", 32'(bus1.rdata), 32'h0);
      checkOutput("epoch reset mem bus", 32'({bus1.mem_addr, bus1.mem_wdata}), 32'h0);
      repeat (2) @(negedge clk);
      rst1 = 1'b1;
      model_reset();
      for (int n = 0; n < 250; n++) begin
        model_check();
        for (int i = 0; i < 3; i++) begin
          r[i]   = ($urandom_range(0, 5) == 0);
          w[i]   = 1'($urandom_range(0, 1));
          ra[i]  = 8'h40 | 8'($urandom_range(0, 63));
          rdv[i] = 16'($urandom);
        end
        applyStimulus(r, w, {ra[2], ra[1], ra[0]}, {rdv[2], rdv[1], rdv[0]});
        model_step(r, w, ra, rdv);
        @(negedge clk);
      end
    end
    applyStimulus(3'b000, 3'b000, 24'h0, 48'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the single-port data memory between the three data-memory masters of the processor: control-unit load/store (requester 0), stack PUSH/POP (requester 1) and crypto core key load/save (requester 2). Each requester issues a one-cycle request pulse. The arbiter latches the request, grants memory access round-robin, waits out the memory read latency and returns a one-cycle `done` pulse with read data. It sits between those masters and the data memory and replaces their direct `mem_read`/`mem_write` wiring.

## Interface
- `ADDR_W`, 8, data memory address width
- `DATA_W`, 16, data word width
- `MEM_LAT`, 1, read latency of data memory in cycles (legal 1..3)

- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req`  in  3  per-requester one-cycle request pulse (bit i = requester i)
- `we`  in  3  per-requester write enable, sampled with `req`
- `addr`  in  3*ADDR_W  packed addresses, requester i at `[i*ADDR_W +: ADDR_W]`
- `wdata`  in  3*DATA_W  packed write data, same packing
- `gnt`  out  3  one-hot, high during the ISSUE cycle of the served requester
- `done`  out  3  one-hot, one-cycle completion pulse
- `rdata`  out  DATA_W  read data, valid only while a `done` bit is high after a read
- `collision`  out  3  sticky per-requester error: a request arrived while one was still pending
- `busy`  out  1  high when state != IDLE or any request is pending
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable, qualified by `mem_en`
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid `MEM_LAT` cycles after the `mem_en` cycle

## Operation
- Pending stage, per requester i: `req[i]` high at an edge sets `pend[i]` and captures `we`, `addr` and `wdata` into the slot.
  - If `pend[i]` is already set and requester i is not in RESP, the request is ignored, the slot is unchanged, and `collision[i]` is set.
  - `collision[i]` clears only on reset.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if any `pend` is set, pick the winner round-robin, starting at `(last+1) mod 3`, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: `mem_en`=1, `mem_we`/`mem_addr`/`mem_wdata` come from the winner slot, `gnt[winner]`=1. A write goes to RESP. A read goes to WAIT and loads the latency counter with `MEM_LAT`.
  - WAIT: the counter decrements each cycle. In the cycle where the counter equals 1, `mem_rdata` is captured into the `rdata` register, and the next state is RESP.
  - RESP: `done[winner]`=1, `pend[winner]` is cleared, `last` is updated to the winner, then go to IDLE.
- `rdata` holds its last captured value outside RESP. Consumers must only sample it with `done`.
- A write never modifies `rdata`.
- Same-cycle set and clear: if `req[i]` arrives in the RESP cycle of requester i, the new request is accepted (set wins over clear). `collision` is not set.
- While one requester is served, other requesters' pulses are latched normally and served in later rounds.
- No starvation: with all three pending continuously, service order repeats 0,1,2.

## Timing
- Reset values: `gnt`=0, `done`=0, `rdata`=0, `collision`=0, `busy`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0. Also `pend`=0, state=IDLE, `last`=2, so requester 0 has first priority.
- Reset asserted mid-transaction: all pending requests are discarded and `mem_en` drops immediately (asynchronous). No `done` is issued for the aborted request.
- All outputs are decoded from registered state and slot registers; there is no combinational path from `req` to `mem_*`.
- Read latency, with `req` pulse in cycle 0:
  - cycle 1: IDLE
  - cycle 2: ISSUE
  - cycles 3..2+`MEM_LAT`: WAIT
  - cycle 3+`MEM_LAT`: `done`
  - With `MEM_LAT`=1, `done` is in cycle 4.
- Write latency, with `req` in cycle 0: ISSUE in cycle 2, `done` in cycle 3. Memory is written at the edge ending cycle 2.
- Back-to-back service: IDLE always separates two transactions.
  - Minimum spacing between ISSUE cycles is 3 for writes and 3+`MEM_LAT` for reads.

## Test plan
- Single read, `MEM_LAT`=1: requester 0, addr 0x10, memory holds 0xBEEF.
  - Required: `gnt`=001 in cycle 2, `mem_addr`=0x10 with `mem_we`=0, `done`=001 in cycle 4, `rdata`=0xBEEF.
- Single write: requester 1, addr 0xFF, data 0x1234.
  - Required: ISSUE in cycle 2 with `mem_we`=1 and `mem_wdata`=0x1234, `done`=010 in cycle 3, `rdata` unchanged.
  - A following read of 0xFF returns 0x1234.
- Round-robin: pulse all three `req` in the same cycle, all reads.
  - Required: `gnt` sequence 001, 010, 100 on consecutive transactions.
  - Repeating the stimulus gives the same order.
- Collision: requester 2 pulses `req` twice, 1 cycle apart, with different addresses.
  - Required: only the first address is issued, `collision`=100, one `done`.
  - The sticky bit persists until `rst`.
- Re-request in RESP: requester 0 pulses `req` exactly in its `done` cycle.
  - Required: no collision, and a second transaction is issued with the new address.
- Reset mid-WAIT with `MEM_LAT`=3: drop `rst` during WAIT.
  - Required: all outputs return to their reset values immediately, `busy`=0.
  - No `done` after release.
